// File: rtl/user_obi_demux_pkg.sv
// Shared definitions for the user-domain OBI demultiplexer.
// Holds the address-rule type, the user-domain subordinate map (base and size
// per subordinate) and the demux output enumeration. The user_obi_demux
// parameter defaults are derived from the user-domain subordinate map.
package user_obi_demux_pkg;

  // One address-map rule: inclusive start and end address of a subordinate.
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

  localparam int unsigned NumUserDomainSubordinates = 2;

  localparam logic [31:0] UserBaseAddr = 32'h2000_0000;
  localparam logic [31:0] UserSbr0Base = UserBaseAddr;
  localparam logic [31:0] UserSbr0Size = 32'h0000_1000;
  localparam logic [31:0] UserSbr1Base = 32'h2000_1000;
  localparam logic [31:0] UserSbr1Size = 32'h0000_1000;

  localparam logic [31:0] UserErrData = 32'hBADC_AB1E;

  // The error subordinate sits one past the last real subordinate.
  typedef enum logic [1:0] {
    UserSbr0  = 2'd0,
    UserSbr1  = 2'd1,
    UserError = 2'(NumUserDomainSubordinates)
  } user_demux_outputs_e;

  localparam addr_map_rule_t [NumUserDomainSubordinates-1:0] UserAddrMap = '{
    '{idx: 32'(UserSbr1), start_addr: UserSbr1Base, end_addr: UserSbr1Base + UserSbr1Size - 32'd1},
    '{idx: 32'(UserSbr0), start_addr: UserSbr0Base, end_addr: UserSbr0Base + UserSbr0Size - 32'd1}
  };

  // Packed start/end vectors, index 0 in the LSBs.
  localparam logic [NumUserDomainSubordinates*32-1:0] UserSbrStart =
    {UserAddrMap[1].start_addr, UserAddrMap[0].start_addr};
  localparam logic [NumUserDomainSubordinates*32-1:0] UserSbrEnd =
    {UserAddrMap[1].end_addr, UserAddrMap[0].end_addr};

endpackage

// File: rtl/user_obi_err_sbr.sv
// Error subordinate for the user-domain OBI demux.
// Every handshake routed here is answered exactly one cycle later with an
// error response carrying the fixed error data and the captured transaction id.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   hs_i           a request was accepted for the error subordinate this cycle
//   aid_i          id of that request
//   rvalid_o       response valid (cycle after hs_i)
//   rdata_o        ErrData resized to DataWidth while rvalid_o, else 0
//   err_o          error flag, equals rvalid_o
//   rid_o          captured id while rvalid_o, else 0
module user_obi_err_sbr #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1,
  parameter logic [31:0] ErrData   = 32'hBADC_AB1E
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 hs_i,
  input  logic [IdWidth-1:0]   aid_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o,
  output logic [IdWidth-1:0]   rid_o
);

  localparam logic [DataWidth-1:0] ErrDataW = DataWidth'(ErrData);

  logic               rvalid_q;
  logic [IdWidth-1:0] rid_q;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= hs_i;
      rid_q    <= hs_i ? aid_i : '0;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = rvalid_q;
  assign rdata_o  = rvalid_q ? ErrDataW : '0;
  assign rid_o    = rid_q;

endmodule

// File: rtl/user_obi_demux.sv
// User-domain OBI demultiplexer.
// Routes each manager request to the lowest-indexed subordinate whose address
// rule contains the address, or to the internal error subordinate (index
// NumSbr) when no rule matches. Responses come back in order because a switch
// to a different target is stalled while transactions are still in flight.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   mgr_*                 OBI manager-side request (in) and response (out)
//   sbr_req_o/sbr_gnt_i   per-subordinate request/grant
//   sbr_addr_o..aid_o     request fields broadcast to every subordinate
//   sbr_rvalid_i..rid_i   per-subordinate response channels (index 0 in LSBs)
module user_obi_demux
  import user_obi_demux_pkg::*;
#(
  parameter int unsigned NumSbr    = NumUserDomainSubordinates,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned MaxTrans  = 4,
  parameter logic [NumSbr*AddrWidth-1:0] SbrStart = UserSbrStart,
  parameter logic [NumSbr*AddrWidth-1:0] SbrEnd   = UserSbrEnd,
  parameter logic [31:0] ErrData   = UserErrData
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        mgr_req_i,
  output logic                        mgr_gnt_o,
  input  logic [AddrWidth-1:0]        mgr_addr_i,
  input  logic                        mgr_we_i,
  input  logic [DataWidth/8-1:0]      mgr_be_i,
  input  logic [DataWidth-1:0]        mgr_wdata_i,
  input  logic [IdWidth-1:0]          mgr_aid_i,
  output logic                        mgr_rvalid_o,
  output logic [DataWidth-1:0]        mgr_rdata_o,
  output logic                        mgr_err_o,
  output logic [IdWidth-1:0]          mgr_rid_o,
  output logic [NumSbr-1:0]           sbr_req_o,
  input  logic [NumSbr-1:0]           sbr_gnt_i,
  output logic [AddrWidth-1:0]        sbr_addr_o,
  output logic                        sbr_we_o,
  output logic [DataWidth/8-1:0]      sbr_be_o,
  output logic [DataWidth-1:0]        sbr_wdata_o,
  output logic [IdWidth-1:0]          sbr_aid_o,
  input  logic [NumSbr-1:0]           sbr_rvalid_i,
  input  logic [NumSbr*DataWidth-1:0] sbr_rdata_i,
  input  logic [NumSbr-1:0]           sbr_err_i,
  input  logic [NumSbr*IdWidth-1:0]   sbr_rid_i
);

  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam int unsigned SelW = $clog2(NumSbr + 1);
  localparam logic [SelW-1:0] ErrIdx = SelW'(NumSbr);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTrans);

  logic [SelW-1:0]      tgt;
  logic [SelW-1:0]      sel_d, sel_q;
  logic [CntW-1:0]      cnt_d, cnt_q;
  logic                 allow, hs, rsp_en;
  logic                 sel_valid, sel_err;
  logic [DataWidth-1:0] sel_rdata;
  logic [IdWidth-1:0]   sel_rid;
  logic                 err_rvalid, err_err;
  logic [DataWidth-1:0] err_rdata;
  logic [IdWidth-1:0]   err_rid;

  // Request fields go to every subordinate; only sbr_req_o qualifies them.
  assign sbr_addr_o  = mgr_addr_i;
  assign sbr_we_o    = mgr_we_i;
  assign sbr_be_o    = mgr_be_i;
  assign sbr_wdata_o = mgr_wdata_i;
  assign sbr_aid_o   = mgr_aid_i;

  // Decode scans from the top index down so the lowest matching rule wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    tgt = ErrIdx;
    for (int i = int'(NumSbr) - 1; i >= 0; i--) begin
      if (mgr_addr_i >= SbrStart[i*AddrWidth +: AddrWidth] &&
          mgr_addr_i <= SbrEnd[i*AddrWidth +: AddrWidth]) begin
        tgt = SelW'(i);
      end
    end
  end

  // A target switch waits until the previous target has drained.
  assign allow = !rst_i && (cnt_q < MaxCnt) && (cnt_q == '0 || tgt == sel_q);

  always_comb begin
    sbr_req_o = '0;
    mgr_gnt_o = 1'b0;
    if (allow) begin
      if (tgt == ErrIdx) mgr_gnt_o = mgr_req_i;
      for (int i = 0; i < int'(NumSbr); i++) begin
        if (tgt == SelW'(i)) begin
          sbr_req_o[i] = mgr_req_i;
          mgr_gnt_o    = sbr_gnt_i[i];
        end
      end
    end
  end

  assign hs = mgr_req_i & mgr_gnt_o;

  user_obi_err_sbr #(
    .DataWidth (DataWidth),
    .IdWidth   (IdWidth),
    .ErrData   (ErrData)
  ) i_err_sbr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hs_i     (hs && (tgt == ErrIdx)),
    .aid_i    (mgr_aid_i),
    .rvalid_o (err_rvalid),
    .rdata_o  (err_rdata),
    .err_o    (err_err),
    .rid_o    (err_rid)
  );

  // Only the target owning the in-flight transactions is listened to.
  always_comb begin
    sel_valid = 1'b0;
    sel_rdata = '0;
    sel_err   = 1'b0;
    sel_rid   = '0;
    if (sel_q == ErrIdx) begin
      sel_valid = err_rvalid;
      sel_rdata = err_rdata;
      sel_err   = err_err;
      sel_rid   = err_rid;
    end
    for (int i = 0; i < int'(NumSbr); i++) begin
      if (sel_q == SelW'(i)) begin
        sel_valid = sbr_rvalid_i[i];
        sel_rdata = sbr_rdata_i[i*DataWidth +: DataWidth];
        sel_err   = sbr_err_i[i];
        sel_rid   = sbr_rid_i[i*IdWidth +: IdWidth];
      end
    end
  end

  // With nothing outstanding any response is stray and is dropped.
  assign rsp_en       = !rst_i && (cnt_q != '0);
  assign mgr_rvalid_o = rsp_en & sel_valid;
  assign mgr_rdata_o  = rsp_en ? sel_rdata : '0;
  assign mgr_err_o    = rsp_en & sel_err;
  assign mgr_rid_o    = rsp_en ? sel_rid : '0;

  assign cnt_d = cnt_q + CntW'(hs) - CntW'(mgr_rvalid_o);
  assign sel_d = hs ? tgt : sel_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sel_q <= ErrIdx;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

`ifndef SYNTHESIS
  a_cnt_max : assert property (@(posedge clk_i) cnt_q <= MaxCnt)
    else $error("outstanding count exceeds MaxTrans");
  a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(sel_valid && cnt_q == '0))
    else $error("response with no outstanding transaction");
  a_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (mgr_req_i && !mgr_gnt_o) |=>
      $stable({mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i, mgr_aid_i}))
    else $error("request fields changed while waiting for grant");
`endif

endmodule

// File: tb/tb_user_obi_demux.sv
// Self-checking bench for user_obi_demux with default parameters
// (2 subordinates at 0x2000_0000 and 0x2000_1000, MaxTrans 4).
// A behavioural model follows outstanding transactions and checks every
// output on each falling edge; directed scenarios add literal expectations.
module tb_user_obi_demux;

  localparam int N  = 2;
  localparam int MT = 4;
  localparam logic [31:0] ERR_DATA = 32'hBADC_AB1E;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'hF;
  logic [31:0] wdata = '0;
  logic [0:0]  aid = '0;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic [0:0]  rid;
  logic [N-1:0] s_req;
  logic [N-1:0] s_gnt = '0;
  logic [31:0] s_addr, s_wdata;
  logic        s_we;
  logic [3:0]  s_be;
  logic [0:0]  s_aid;
  logic [N-1:0] s_rvalid = '0;
  logic [31:0] rd0 = '0, rd1 = '0;
  logic [N-1:0] s_err = '0;
  logic [N-1:0] s_rid = '0;

  int checks = 0;
  int errors = 0;

  user_obi_demux dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mgr_req_i    (req),
    .mgr_gnt_o    (gnt),
    .mgr_addr_i   (addr),
    .mgr_we_i     (we),
    .mgr_be_i     (be),
    .mgr_wdata_i  (wdata),
    .mgr_aid_i    (aid),
    .mgr_rvalid_o (rvalid),
    .mgr_rdata_o  (rdata),
    .mgr_err_o    (err),
    .mgr_rid_o    (rid),
    .sbr_req_o    (s_req),
    .sbr_gnt_i    (s_gnt),
    .sbr_addr_o   (s_addr),
    .sbr_we_o     (s_we),
    .sbr_be_o     (s_be),
    .sbr_wdata_o  (s_wdata),
    .sbr_aid_o    (s_aid),
    .sbr_rvalid_i (s_rvalid),
    .sbr_rdata_i  ({rd1, rd0}),
    .sbr_err_i    (s_err),
    .sbr_rid_i    (s_rid)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Address map as stated: two inclusive 4 KiB windows, everything else errors.
  function automatic int decode(input logic [31:0] a);
    if (a >= 32'h2000_0000 && a <= 32'h2000_0FFF) return 0;
    if (a >= 32'h2000_1000 && a <= 32'h2000_1FFF) return 1;
    return N;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  int   m_cnt = 0;
  int   m_sel = N;
  bit   m_ep = 1'b0;     // error response due this cycle
  logic m_erid = 1'b0;

  initial forever begin
    int t;
    bit al, hs, cmp_data;
    logic [N-1:0] e_req;
    logic e_gnt, e_rv, e_err;
    logic [31:0] e_rdata;
    logic e_rid;
    @(negedge clk);
    t = decode(addr);
    e_req = '0; e_gnt = 1'b0; e_rv = 1'b0; e_err = 1'b0; e_rdata = '0; e_rid = 1'b0;
    cmp_data = 1'b1;
    al = !rst && m_cnt < MT && (m_cnt == 0 || t == m_sel);
    if (al) begin
      if (t == N) e_gnt = req;
      else begin
        e_gnt = s_gnt[t];
        e_req[t] = req;
      end
    end
    if (!rst && m_cnt != 0) begin
      if (m_sel == N) begin
        e_rv = m_ep; e_err = m_ep; e_rid = m_erid;
        e_rdata = m_ep ? ERR_DATA : 32'h0;
        cmp_data = m_ep;
      end else begin
        e_rv = s_rvalid[m_sel];
        e_err = s_err[m_sel];
        e_rid = s_rid[m_sel];
        e_rdata = (m_sel == 0) ? rd0 : rd1;
      end
    end
    check("m_gnt", 64'(gnt), 64'(e_gnt));
    check("m_sbr_req", 64'(s_req), 64'(e_req));
    check("m_rvalid", 64'(rvalid), 64'(e_rv));
    check("m_cnt", 64'(dut.cnt_q), 64'(m_cnt));
    check("m_bcast_addr", 64'(s_addr), 64'(addr));
    if (cmp_data) begin
      check("m_rdata", 64'(rdata), 64'(e_rdata));
      check("m_err", 64'(err), 64'(e_err));
      check("m_rid", 64'(rid), 64'(e_rid));
    end
    if (rst) begin
      m_cnt = 0; m_sel = N; m_ep = 1'b0; m_erid = 1'b0;
    end else begin
      hs = req && e_gnt;
      m_cnt = m_cnt + int'(hs) - int'(e_rv);
      m_ep = hs && (t == N);
      m_erid = aid[0];
      if (hs) m_sel = t;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    req = 1'b0; s_gnt = '0; s_rvalid = '0; s_err = '0; s_rid = '0; aid = '0;
  endtask

  logic [31:0] b_addr [5] = '{32'h2000_0FFF, 32'h2000_1000, 32'h2000_1FFF, 32'h2000_2000, 32'h1FFF_FFFF};
  logic [1:0]  b_req  [5] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b00};

  initial begin
    // Reset
    step(); step();
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    rst = 1'b0;
    step();

    // Single read to sbr0
    req = 1'b1; addr = 32'h2000_0004; s_gnt = 2'b01;
    settle();
    check("a_gnt", 64'(gnt), 64'd1);
    check("a_sbr_req", 64'(s_req), 64'b01);
    step();
    idle(); s_rvalid = 2'b01; rd0 = 32'h1234_5678;
    settle();
    check("a_rvalid", 64'(rvalid), 64'd1);
    check("a_rdata", 64'(rdata), 64'h1234_5678);
    check("a_err", 64'(err), 64'd0);
    step();
    idle();
    settle();
    check("a_cnt", 64'(dut.cnt_q), 64'd0);
    step();

    // Three outstanding to sbr0, then a switch to sbr1 must wait for drain
    for (int i = 0; i < 3; i++) begin
      req = 1'b1; addr = 32'h2000_0000 + 32'(i * 4); s_gnt = 2'b01;
      step();
    end
    addr = 32'h2000_1000; s_gnt = 2'b11;
    settle();
    check("b_stall_req", 64'(s_req), 64'd0);
    check("b_stall_gnt", 64'(gnt), 64'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      s_rvalid = 2'b01; rd0 = 32'(i);
      settle();
      check("b_drain_gnt", 64'(gnt), 64'd0);
      step();
    end
    s_rvalid = '0;
    settle();
    check("b_switch_req", 64'(s_req), 64'b10);
    check("b_switch_gnt", 64'(gnt), 64'd1);
    step();
    idle(); s_rvalid = 2'b10; rd1 = 32'h0000_00B1;
    step();
    idle();
    step();

    // MaxTrans limit on sbr1
    for (int i = 0; i < 4; i++) begin
      req = 1'b1; addr = 32'h2000_1000 + 32'(i * 4); s_gnt = 2'b10;
      step();
    end
    addr = 32'h2000_1010;
    settle();
    check("c_full_gnt", 64'(gnt), 64'd0);
    check("c_full_cnt", 64'(dut.cnt_q), 64'd4);
    step();
    s_rvalid = 2'b10; rd1 = 32'h0000_00AA;
    settle();
    check("c_rv_fwd", 64'(rvalid), 64'd1);
    check("c_rv_gnt", 64'(gnt), 64'd0);
    step();
    s_rvalid = '0;
    settle();
    check("c_fifth_gnt", 64'(gnt), 64'd1);
    step();
    idle();
    settle();
    check("c_cnt_back", 64'(dut.cnt_q), 64'd4);
    for (int i = 0; i < 4; i++) begin
      s_rvalid = 2'b10;
      step();
    end
    idle();
    step();

    // Unmapped addresses -> error subordinate, back-to-back
    req = 1'b1; addr = 32'h3000_0000; aid = 1'b1; s_gnt = 2'b11;
    settle();
    check("d_gnt", 64'(gnt), 64'd1);
    check("d_sbr_req", 64'(s_req), 64'd0);
    step();
    addr = 32'h1000_0000; aid = 1'b0;
    settle();
    check("d_rvalid", 64'(rvalid), 64'd1);
    check("d_err", 64'(err), 64'd1);
    check("d_rdata", 64'(rdata), 64'hBADC_AB1E);
    check("d_rid", 64'(rid), 64'd1);
    step();
    idle();
    settle();
    check("d_rvalid2", 64'(rvalid), 64'd1);
    check("d_rid2", 64'(rid), 64'd0);
    step();
    settle();
    check("d_cnt", 64'(dut.cnt_q), 64'd0);
    step();

    // Reset with two outstanding sbr0 transactions
    req = 1'b1; addr = 32'h2000_0000; s_gnt = 2'b01;
    step();
    addr = 32'h2000_0004;
    step();
    rst = 1'b1; s_rvalid = 2'b01; rd0 = 32'h0000_DEAD;
    settle();
    check("e_rst_gnt", 64'(gnt), 64'd0);
    check("e_rst_req", 64'(s_req), 64'd0);
    check("e_rst_rvalid", 64'(rvalid), 64'd0);
    step();
    rst = 1'b0; req = 1'b0; s_gnt = '0;
    settle();
    check("e_late_rvalid", 64'(rvalid), 64'd0);
    check("e_late_cnt", 64'(dut.cnt_q), 64'd0);
    step();
    s_rvalid = '0; req = 1'b1; addr = 32'h2000_0000; s_gnt = 2'b01;
    settle();
    check("e_new_gnt", 64'(gnt), 64'd1);
    check("e_new_req", 64'(s_req), 64'b01);
    step();
    idle(); s_rvalid = 2'b01;
    step();
    idle();
    step();

    // Simultaneous request and response at cnt 2
    req = 1'b1; addr = 32'h2000_0100; s_gnt = 2'b01;
    step();
    addr = 32'h2000_0104;
    step();
    addr = 32'h2000_0108; s_rvalid = 2'b01; rd0 = 32'hCAFE_F00D; s_rid = 2'b01;
    settle();
    check("f_gnt", 64'(gnt), 64'd1);
    check("f_rdata", 64'(rdata), 64'hCAFE_F00D);
    check("f_rid", 64'(rid), 64'd1);
    step();
    idle();
    settle();
    check("f_cnt", 64'(dut.cnt_q), 64'd2);
    s_rvalid = 2'b01; s_err = 2'b01;
    settle();
    check("f_err_fwd", 64'(err), 64'd1);
    step();
    s_err = '0;
    step();
    idle();
    step();

    // Rule boundaries
    for (int i = 0; i < 5; i++) begin
      req = 1'b1; addr = b_addr[i]; s_gnt = 2'b11;
      settle();
      check("g_bound_req", 64'(s_req), 64'(b_req[i]));
      check("g_bound_gnt", 64'(gnt), 64'd1);
      step();
      idle(); s_rvalid = b_req[i];
      settle();
      check("g_bound_rv", 64'(rvalid), 64'd1);
      step();
      idle();
    end
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
